prga_decrypt: RTL and testbench



---
 rtl/prga_decrypt.sv | 244 ++++++++++++++++++++++++
 tb/tb_prga_decrypt.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt.sv
// ---------------------------------------------------------------------------
// prga_decrypt
//
// Third stage of the RC4 decryption datapath. Once key scheduling has
// permuted S memory, this block runs the RC4 pseudo-random generation loop
// over S. It XORs each keystream byte with the matching encrypted-ROM byte
// and writes the plaintext into the decrypted RAM. The loop handler starts
// the block with the start_flag/done_flag level handshake. S memory belongs
// to this block while it is busy.
//
// Every memory has a registered address and an unregistered q. Data for an
// address driven in cycle c is sampled at the end of cycle c+1, so each read
// is followed by one WAIT state. Each byte takes 12 cycles.
//
// Optional build macro: PRGA_VALID_CHECK_EN
//   defined   - plaintext must be 'a'..'z' or space; the first bad byte is
//               not written, fail_flag is raised and the run ends.
//   undefined - no check; fail_flag is tied 0; all MSG_LEN bytes are written.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   start_flag             level request from the loop handler
//   done_flag              high while the block sits in DONE
//   s_address/s_data/s_wren/s_q        S memory port
//   rom_address/rom_q                  encrypted ROM port
//   dec_address/dec_data/dec_wren      decrypted RAM write port
//   fail_flag              plaintext validity failure (optional feature)
// ---------------------------------------------------------------------------
module prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_flag,
    output logic              done_flag,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              fail_flag
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, INC_I, WAIT_SI, READ_SI, WAIT_SJ, READ_SJ, WRITE_SI,
        WRITE_SJ, ISSUE_F, WAIT_F, READ_F, WRITE_D, NEXT, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [7:0]        si_q, si_d, sj_q, sj_d;
    logic [7:0]        f_q, f_d, enc_q, enc_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic              done_q, done_d;
    logic [7:0]        s_addr_q, s_addr_d, s_data_q, s_data_d;
    logic              s_wren_q, s_wren_d;
    logic [MSG_AW-1:0] rom_addr_q, rom_addr_d, dec_addr_q, dec_addr_d;
    logic              dec_wren_q, dec_wren_d;
    logic              stop_run;

`ifdef PRGA_VALID_CHECK_EN
    logic fail_q, fail_d;

    // Accepted plaintext alphabet: lowercase letters and space.
    function automatic logic plain_ok(input logic [7:0] p);
        return ((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20);
    endfunction

    // A rejected byte ends the run after the current byte completes.
    assign stop_run  = (k_q == K_LAST) || fail_q;
    assign fail_flag = fail_q;
`else
    assign stop_run  = (k_q == K_LAST);
    assign fail_flag = 1'b0;
`endif

    // Next-state logic. Every output is a flop, so a value that must be on a
    // port during state X is loaded on the transition into X. The write
    // enables drop back to 0 unless the next state is a write state.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        f_d        = f_q;
        enc_d      = enc_q;
        k_d        = k_q;
        done_d     = done_q;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        s_wren_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        dec_addr_d = dec_addr_q;
        dec_wren_d = 1'b0;
`ifdef PRGA_VALID_CHECK_EN
        fail_d     = fail_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_flag) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = '0;
`ifdef PRGA_VALID_CHECK_EN
                    fail_d  = 1'b0;
`endif
                    state_d = INC_I;
                end
            end
            INC_I: begin
                i_d      = i_q + 8'd1;
                s_addr_d = i_q + 8'd1;
                state_d  = WAIT_SI;
            end
            WAIT_SI: state_d = READ_SI;
            READ_SI: begin
                si_d     = s_q;
                j_d      = j_q + s_q;
                s_addr_d = j_q + s_q;
                state_d  = WAIT_SJ;
            end
            WAIT_SJ: state_d = READ_SJ;
            READ_SJ: begin
                // S[j] arrives now; it goes straight out as the S[i] write data.
                sj_d     = s_q;
                s_addr_d = i_q;
                s_data_d = s_q;
                s_wren_d = 1'b1;
                state_d  = WRITE_SI;
            end
            WRITE_SI: begin
                s_addr_d = j_q;
                s_data_d = si_q;
                s_wren_d = 1'b1;
                state_d  = WRITE_SJ;
            end
            WRITE_SJ: state_d = ISSUE_F;
            ISSUE_F: begin
                // The sum is symmetric, so the swap does not change the index.
                s_addr_d   = si_q + sj_q;
                rom_addr_d = k_q;
                state_d    = WAIT_F;
            end
            WAIT_F: state_d = READ_F;
            READ_F: begin
                f_d        = s_q;
                enc_d      = rom_q;
                dec_addr_d = k_q;
`ifdef PRGA_VALID_CHECK_EN
                dec_wren_d = plain_ok(s_q ^ rom_q);
`else
                dec_wren_d = 1'b1;
`endif
                state_d    = WRITE_D;
            end
            WRITE_D: begin
`ifdef PRGA_VALID_CHECK_EN
                if (!plain_ok(f_q ^ enc_q)) begin
                    fail_d = 1'b1;
                end
`endif
                state_d = NEXT;
            end
            NEXT: begin
                if (stop_run) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = INC_I;
                end
            end
            DONE: begin
                if (!start_flag) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. A low reset_n abandons any run in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            f_q        <= 8'd0;
            enc_q      <= 8'd0;
            k_q        <= '0;
            done_q     <= 1'b0;
            s_addr_q   <= 8'd0;
            s_data_q   <= 8'd0;
            s_wren_q   <= 1'b0;
            rom_addr_q <= '0;
            dec_addr_q <= '0;
            dec_wren_q <= 1'b0;
`ifdef PRGA_VALID_CHECK_EN
            fail_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            f_q        <= f_d;
            enc_q      <= enc_d;
            k_q        <= k_d;
            done_q     <= done_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            s_wren_q   <= s_wren_d;
            rom_addr_q <= rom_addr_d;
            dec_addr_q <= dec_addr_d;
            dec_wren_q <= dec_wren_d;
`ifdef PRGA_VALID_CHECK_EN
            fail_q     <= fail_d;
`endif
        end
    end

    assign done_flag   = done_q;
    assign s_address   = s_addr_q;
    assign s_data      = s_data_q;
    assign s_wren      = s_wren_q;
    assign rom_address = rom_addr_q;
    assign dec_address = dec_addr_q;
    // XOR of the two bytes captured in READ_F; stable throughout WRITE_D.
    assign dec_data    = f_q ^ enc_q;
    assign dec_wren    = dec_wren_q;

endmodule

// File: tb/tb_prga_decrypt.sv
// ---------------------------------------------------------------------------
// tb_prga_decrypt
//
// Self-checking bench for prga_decrypt. Behavioural S memory, encrypted ROM
// and decrypted RAM models share the DUT's registered-address timing. A
// reference RC4 model fills a scoreboard queue when a run is started. The
// queue is popped as the DUT writes plaintext. Honours PRGA_VALID_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_prga_decrypt;

    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start_flag = 1'b0;
    logic              done_flag;
    logic [7:0]        s_address, s_data, s_q;
    logic              s_wren;
    logic [MSG_AW-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;
    logic              fail_flag;

    logic [7:0]        s_mem [256];
    logic [7:0]        rom_mem [2**MSG_AW];
    logic [7:0]        dec_mem [2**MSG_AW];
    logic [7:0]        model_s [256];
    logic [7:0]        s_addr_r = 8'd0;
    logic [MSG_AW-1:0] rom_addr_r = '0;

    logic [MSG_AW-1:0] exp_addr_q [$];
    logic [7:0]        exp_data_q [$];

    int tests_run = 0;
    int tests_failed = 0;
    int writes_seen = 0;

    prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
        .clk(clk), .reset_n(reset_n), .start_flag(start_flag),
        .done_flag(done_flag), .s_address(s_address), .s_data(s_data),
        .s_wren(s_wren), .s_q(s_q), .rom_address(rom_address), .rom_q(rom_q),
        .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
        .fail_flag(fail_flag)
    );

    always #5 clk = ~clk;

    // Memory models: address registered on the edge, q read straight from
    // the array through the registered address.
    always @(posedge clk) begin
        s_addr_r   <= s_address;
        rom_addr_r <= rom_address;
        if (s_wren) s_mem[s_address] <= s_data;
        if (dec_wren) dec_mem[dec_address] <= dec_data;
    end

    assign s_q   = s_q_sel(s_addr_r);
    assign rom_q = rom_mem[rom_addr_r];

    function automatic logic [7:0] s_q_sel(input logic [7:0] a);
        return s_mem[a];
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: each plaintext write is matched against the oldest
    // expected entry, and the two write enables must never overlap.
    always @(negedge clk) begin
        if (reset_n && dec_wren) begin
            writes_seen++;
            if (exp_data_q.size() == 0) begin
                checkOutput("sb_unexpected_write", 32'(exp_data_q.size()), 32'd1);
            end else begin
                checkOutput("dec_address", 32'(dec_address), 32'(exp_addr_q.pop_front()));
                checkOutput("dec_data", 32'(dec_data), 32'(exp_data_q.pop_front()));
            end
        end
        if (s_wren || dec_wren) begin
            checkOutput("wren_exclusive", 32'(s_wren & dec_wren), 32'd0);
        end
    end

    // Runs the reference RC4 loop over a snapshot of S, pushes the expected
    // writes and raises start. Ends #1 after the edge that samples start.
    task automatic applyStimulus();
        logic [7:0] ii, jj, tmp, idx;
        model_s = s_mem;
        ii = 8'd0;
        jj = 8'd0;
        for (int k = 0; k < MSG_LEN; k++) begin
            ii = ii + 8'd1;
            jj = jj + model_s[ii];
            tmp = model_s[ii];
            model_s[ii] = model_s[jj];
            model_s[jj] = tmp;
            idx = model_s[ii] + model_s[jj];
            exp_addr_q.push_back(MSG_AW'(k));
            exp_data_q.push_back(rom_mem[k] ^ model_s[idx]);
        end
        start_flag = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done_flag rises (bounded), optionally dropping or
    // pulsing start mid-run, then checks the latency.
    task automatic waitDone(input int expected, input bit release_start, input int pulse_at);
        int  edges = 0;
        bit  seen = 1'b0;
        while (!seen && edges < 2000) begin
            @(posedge clk);
            #1;
            edges++;
            if (release_start && edges == 2) start_flag = 1'b0;
            if (edges == pulse_at) start_flag = 1'b1;
            if (edges == pulse_at + 1) start_flag = 1'b0;
            if (done_flag) seen = 1'b1;
        end
        checkOutput("done_latency", 32'(edges), 32'(expected));
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_done"}, 32'(done_flag), 32'd0);
        checkOutput({phase, "_s_address"}, 32'(s_address), 32'd0);
        checkOutput({phase, "_s_data"}, 32'(s_data), 32'd0);
        checkOutput({phase, "_s_wren"}, 32'(s_wren), 32'd0);
        checkOutput({phase, "_rom_address"}, 32'(rom_address), 32'd0);
        checkOutput({phase, "_dec_address"}, 32'(dec_address), 32'd0);
        checkOutput({phase, "_dec_data"}, 32'(dec_data), 32'd0);
        checkOutput({phase, "_dec_wren"}, 32'(dec_wren), 32'd0);
        checkOutput({phase, "_fail"}, 32'(fail_flag), 32'd0);
    endtask

    task automatic checkFinalS(input string tag);
        int mism = 0;
        for (int n = 0; n < 256; n++) begin
            if (s_mem[n] !== model_s[n]) mism++;
        end
        checkOutput(tag, 32'(mism), 32'd0);
    endtask

    // Directed sequence: reset, then the scenarios for the configured build.
    initial begin
        for (int n = 0; n < 256; n++) s_mem[n] <= 8'(n);
        for (int n = 0; n < 2**MSG_AW; n++) begin
            rom_mem[n] = 8'($urandom_range(255));
            dec_mem[n] <= 8'h00;
        end
        rom_mem[0] = 8'h63;
        rom_mem[1] = 8'h66;
        rom_mem[2] = 8'h6E;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef PRGA_VALID_CHECK_EN
        // Identity S and ROM[0]=0 give plaintext 0x02, which is rejected.
        rom_mem[0] = 8'h00;
        writes_seen = 0;
        start_flag = 1'b1;
        @(posedge clk);
        #1;
        waitDone(12, 1'b0, -1);
        checkOutput("vc_fail_flag", 32'(fail_flag), 32'd1);
        checkOutput("vc_no_writes", 32'(writes_seen), 32'd0);
        @(negedge clk);
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("vc_done_drop", 32'(done_flag), 32'd0);
        checkOutput("vc_fail_held", 32'(fail_flag), 32'd1);
        @(negedge clk);
        start_flag = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("vc_fail_clear_on_start", 32'(fail_flag), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("vc_reset");
`else
        // Full run from identity S with start held high.
        writes_seen = 0;
        applyStimulus();
        waitDone(12 * MSG_LEN, 1'b0, -1);
        checkOutput("ram0", 32'(dec_mem[0]), 32'h61);
        checkOutput("ram1", 32'(dec_mem[1]), 32'h63);
        checkOutput("ram2", 32'(dec_mem[2]), 32'h69);
        checkOutput("run1_writes", 32'(writes_seen), 32'(MSG_LEN));
        checkOutput("run1_drained", 32'(exp_data_q.size()), 32'd0);
        checkFinalS("run1_s_final");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_hold", 32'(done_flag), 32'd1);
        checkOutput("fail_tied_low", 32'(fail_flag), 32'd0);
        @(negedge clk);
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("done_drop", 32'(done_flag), 32'd0);

        // Reset during byte 5, then a fresh complete run from the new S.
        @(negedge clk);
        applyStimulus();
        repeat (64) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("midrun_reset");
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        writes_seen = 0;
        applyStimulus();
        waitDone(12 * MSG_LEN, 1'b0, -1);
        checkOutput("run2_writes", 32'(writes_seen), 32'(MSG_LEN));
        checkOutput("run2_drained", 32'(exp_data_q.size()), 32'd0);
        checkFinalS("run2_s_final");
        @(negedge clk);
        start_flag = 1'b0;
        @(posedge clk);

        // Start released early and re-pulsed mid-run: no restart.
        @(negedge clk);
        writes_seen = 0;
        applyStimulus();
        waitDone(12 * MSG_LEN, 1'b1, 100);
        checkOutput("run3_writes", 32'(writes_seen), 32'(MSG_LEN));
        checkOutput("run3_drained", 32'(exp_data_q.size()), 32'd0);
        checkFinalS("run3_s_final");
        @(posedge clk);
        #1;
        checkOutput("run3_done_one_cycle", 32'(done_flag), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
